uart_boot_loader: RTL and testbench

//  Upstream of the core's instruction/data memory on the ZedBoard top. Receives a program image over UART
//  (8N1) and writes it word-by-word into memory through a single write port. Holds the core in reset
//  (core_rst_n) until a complete, checksum-valid image has been loaded.

---
 rtl/uart_boot_loader.sv | 196 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART 8N1 boot loader: receives a framed, checksummed program image and writes it
// word by word into the core's memory, holding the core in reset until the image verifies.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int AWIDTH       = 12,
  parameter int XLEN         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic              core_rst_n,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int          CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] MAX_LEN   = 32'd1 << AWIDTH;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_LEN, P_DATA, P_SUM, P_DONE, P_ERR} p_state_t;

  rx_state_t        rx_state_r;
  logic [CW-1:0]    rx_cnt_r;
  logic [2:0]       rx_bit_r;
  logic [7:0]       rx_byte_r;
  logic             rx_valid_r;
  logic             rx_ferr_r;
  logic             rx_meta_r;
  logic             rx_sync_r;
  logic             rx_prev_r;

  p_state_t         p_state_r;
  logic [1:0]       byte_cnt_r;
  logic [31:0]      len_r;
  logic [XLEN-1:0]  word_r;
  logic [7:0]       sum_r;
  logic [AWIDTH:0]  idx_r;

  logic [31:0]      len_nxt_s;
  logic [XLEN-1:0]  word_nxt_s;
  logic [31:0]      idx_inc_s;

  assign len_nxt_s  = {rx_byte_r, len_r[31:8]};
  assign word_nxt_s = {rx_byte_r, word_r[XLEN-1:8]};
  assign idx_inc_s  = 32'(idx_r) + 32'd1;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Bit-timing receiver: start bit re-checked mid-bit, data sampled mid-bit, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_cnt_r   <= CW'(0);
      rx_bit_r   <= 3'd0;
      rx_byte_r  <= 8'd0;
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_valid_r <= 1'b0;
      rx_ferr_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          rx_cnt_r <= CW'(0);
          if (rx_prev_r && !rx_sync_r) rx_state_r <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_r == HALF_LAST) begin
            rx_cnt_r   <= CW'(0);
            rx_bit_r   <= 3'd0;
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r  <= CW'(0);
            rx_byte_r <= {rx_sync_r, rx_byte_r[7:1]};
            rx_bit_r  <= rx_bit_r + 3'd1;
            if (rx_bit_r == 3'd7) rx_state_r <= RX_STOP;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_r == BIT_LAST) begin
            rx_cnt_r   <= CW'(0);
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) rx_valid_r <= 1'b1;
            else           rx_ferr_r  <= 1'b1;
          end else begin
            rx_cnt_r <= rx_cnt_r + CW'(1);
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Frame parser with registered memory port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state_r  <= P_IDLE;
      byte_cnt_r <= 2'd0;
      len_r      <= 32'd0;
      word_r     <= {XLEN{1'b0}};
      sum_r      <= 8'd0;
      idx_r      <= {(AWIDTH+1){1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {AWIDTH{1'b0}};
      mem_wdata  <= {XLEN{1'b0}};
      core_rst_n <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (rx_ferr_r && (p_state_r == P_LEN || p_state_r == P_DATA || p_state_r == P_SUM)) begin
        p_state_r <= P_ERR;
        load_busy <= 1'b0;
        load_err  <= 1'b1;
      end else if (rx_valid_r) begin
        case (p_state_r)
          P_IDLE, P_ERR: begin
            if (rx_byte_r == 8'hA5) begin
              p_state_r  <= P_LEN;
              load_busy  <= 1'b1;
              load_err   <= 1'b0;
              sum_r      <= 8'd0;
              idx_r      <= {(AWIDTH+1){1'b0}};
              byte_cnt_r <= 2'd0;
            end
          end
          P_LEN: begin
            len_r      <= len_nxt_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              if (len_nxt_s == 32'd0) begin
                p_state_r <= P_SUM;
              end else if (len_nxt_s > MAX_LEN) begin
                p_state_r <= P_ERR;
                load_busy <= 1'b0;
                load_err  <= 1'b1;
              end else begin
                p_state_r <= P_DATA;
              end
            end
          end
          P_DATA: begin
            word_r     <= word_nxt_s;
            sum_r      <= sum_r + rx_byte_r;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= idx_r[AWIDTH-1:0];
              mem_wdata <= word_nxt_s;
              idx_r     <= idx_r + {{AWIDTH{1'b0}}, 1'b1};
              if (idx_inc_s == len_r) p_state_r <= P_SUM;
            end
          end
          P_SUM: begin
            load_busy <= 1'b0;
            if (rx_byte_r == sum_r) begin
              p_state_r  <= P_DONE;
              load_done  <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              p_state_r <= P_ERR;
              load_err  <= 1'b1;
            end
          end
          P_DONE:  p_state_r <= P_DONE;
          default: p_state_r <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table-driven frames, hand-written corner
// sequences and randomized images checked against a byte-stream frame model.
module tb_uart_boot_loader;
  localparam int CPB = 8;
  localparam int AW  = 4;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [127:0] bytes;
    int           n;
    int           ferr_at;
    bit           keep;
    bit           exp_done;
    bit           exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rst_n, load_busy, load_done, load_err;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  vec_t          tbl[7];

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .AWIDTH(AW), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  // Record every memory write strobe away from the active edge.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Frame model: A5, 32-bit LE length, words, 8-bit data sum. status 0=incomplete 1=done 2=err
  function automatic void model(input bq_t b, output int status, output wq_t w);
    int i = 0;
    longint n;
    logic [7:0] sum = 8'd0;
    status = 0;
    w = {};
    while (i < b.size() && b[i] != 8'hA5) i++;
    if (i >= b.size()) return;
    i++;
    if (i + 4 > b.size()) return;
    n = longint'({b[i+3], b[i+2], b[i+1], b[i]});
    i += 4;
    if (n > (longint'(1) << AW)) begin
      status = 2;
      return;
    end
    for (longint k = 0; k < n; k++) begin
      if (i + 4 > b.size()) return;
      w.push_back({b[i+3], b[i+2], b[i+1], b[i]});
      sum = sum + b[i] + b[i+1] + b[i+2] + b[i+3];
      i += 4;
    end
    if (i >= b.size()) return;
    status = (b[i] == sum) ? 1 : 2;
  endfunction

  task automatic do_reset();
    uart_rx = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic glitch();
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag, input wq_t w);
    check({tag, " write count"}, 64'(got_data.size()), 64'(w.size()));
    for (int i = 0; i < w.size() && i < got_data.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), 64'(got_addr[i]), 64'(i));
      check($sformatf("%s data[%0d]", tag, i), 64'(got_data[i]), 64'(w[i]));
    end
  endtask

  task automatic run_frame(input string tag, input bq_t q, input int ferr_at,
                           input bit exp_done, input bit exp_err);
    bq_t  seen;
    wq_t  w;
    int   st;
    got_addr = {};
    got_data = {};
    for (int k = 0; k < q.size(); k++) begin
      send_byte(q[k], (k != ferr_at));
      if (ferr_at < 0 || k < ferr_at) seen.push_back(q[k]);
    end
    settle();
    model(seen, st, w);
    check({tag, " load_done"}, 64'(load_done), 64'(exp_done));
    check({tag, " load_err"}, 64'(load_err), 64'(exp_err));
    check({tag, " core_rst_n"}, 64'(core_rst_n), 64'(exp_done));
    check({tag, " load_busy"}, 64'(load_busy), 64'd0);
    check_writes(tag, w);
  endtask

  initial begin
    bq_t q;
    wq_t w;
    int  st;
    tbl[0] = '{128'hA5020000_00130000_00730000_00860000, 14, -1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{128'hA5020000_00130000_00730000_00870000, 14, -1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{128'hA5020000_00130000_00730000_00860000, 14, -1, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{128'h00FF5AA5_00000000_00000000_00000000,  9, -1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{128'hA5020000_00130000_00730000_00860000,  8,  7, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{128'hA5020000_00130000_00730000_00860000, 12, 11, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{128'hA5110000_00000000_00000000_00000000,  5, -1, 1'b0, 1'b0, 1'b1};

    // Reset state, during and just after reset.
    repeat (3) @(negedge clk);
    check("reset outputs", 64'({mem_we, mem_addr, mem_wdata, core_rst_n, load_busy, load_done, load_err}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post-reset outputs", 64'({mem_we, mem_addr, mem_wdata, core_rst_n, load_busy, load_done, load_err}), 64'd0);

    for (int v = 0; v < 7; v++) begin
      if (!tbl[v].keep) do_reset();
      q = {};
      for (int k = 0; k < tbl[v].n; k++) q.push_back(tbl[v].bytes[(15-k)*8 +: 8]);
      run_frame($sformatf("vec%0d", v), q, tbl[v].ferr_at, tbl[v].exp_done, tbl[v].exp_err);
    end

    // Short low pulses in IDLE and inside the length field must not produce bytes.
    do_reset();
    got_addr = {};
    got_data = {};
    glitch();
    @(negedge clk);
    check("glitch idle busy", 64'(load_busy), 64'd0);
    check("glitch idle err", 64'(load_err), 64'd0);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("after A5 busy", 64'(load_busy), 64'd1);
    check("after A5 core_rst_n", 64'(core_rst_n), 64'd0);
    send_byte(8'h00, 1'b1);
    glitch();
    for (int k = 0; k < 4; k++) send_byte(8'h00, 1'b1);
    settle();
    check("glitch frame done", 64'(load_done), 64'd1);
    check("glitch frame writes", 64'(got_data.size()), 64'd0);

    // Reset right after the first write, then a full reload.
    do_reset();
    got_addr = {};
    got_data = {};
    q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    foreach (q[k]) send_byte(q[k], 1'b1);
    settle();
    check("midload first write", 64'(got_data.size()), 64'd1);
    check("midload busy", 64'(load_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midload reset outputs", 64'({mem_we, mem_addr, mem_wdata, core_rst_n, load_busy, load_done, load_err}), 64'd0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
         8'h73, 8'h00, 8'h00, 8'h00, 8'h86};
    run_frame("reload", q, -1, 1'b1, 1'b0);

    // Randomized images: junk prefix, random length (first one fills memory), random bad sums.
    for (int it = 0; it < 6; it++) begin
      int   nw;
      logic [7:0] sum;
      logic [7:0] b;
      do_reset();
      q = {};
      for (int j = $urandom_range(0, 3); j > 0; j--) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        q.push_back(b);
      end
      nw = (it == 0) ? (1 << AW) : $urandom_range(0, 5);
      q.push_back(8'hA5);
      q.push_back(8'(nw));
      q.push_back(8'(nw >> 8));
      q.push_back(8'h00);
      q.push_back(8'h00);
      sum = 8'd0;
      for (int j = 0; j < 4 * nw; j++) begin
        b = 8'($urandom_range(0, 255));
        sum = sum + b;
        q.push_back(b);
      end
      if ($urandom_range(0, 2) == 0) sum = sum + 8'($urandom_range(1, 255));
      q.push_back(sum);
      model(q, st, w);
      run_frame($sformatf("rand%0d", it), q, -1, (st == 1), (st == 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
